// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind a UART receiver: show-ahead storage, sticky error flags,
// level/error interrupt. Optional character timeout under UART_RX_FIFO_TIMEOUT_EN.
module uart_rx_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16,
  localparam int unsigned AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  rx_busy,
  input  logic                  rx_overrun,
  input  logic                  rx_frame_err,
  input  logic [15:0]           prescale,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [AW:0]           count,
  output logic                  empty,
  output logic                  full,
  input  logic [AW:0]           irq_thresh,
  input  logic                  clr_err,
  output logic                  overrun_sticky,
  output logic                  frame_err_sticky,
  output logic                  timeout,
  output logic                  rx_irq
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [AW:0]           count_q, count_d;
  logic                  ovr_q, ovr_d;
  logic                  ferr_q, ferr_d;
  logic                  irq_q, irq_d;
  logic                  timeout_q, timeout_d;
  logic                  push, pop, lvl_d;

  assign empty         = (count_q == '0);
  assign full          = (count_q == (AW+1)'(DEPTH));
  assign s_axis_tready = !full;
  assign count         = count_q;
  assign rd_data       = mem_q[rd_ptr_q];

  assign push = s_axis_tvalid && !full;
  assign pop  = rd_en && !empty;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  // A new error pulse takes priority over a clear arriving in the same cycle.
  always_comb begin
    ovr_d  = rx_overrun   || (ovr_q  && !clr_err);
    ferr_d = rx_frame_err || (ferr_q && !clr_err);
  end

`ifdef UART_RX_FIFO_TIMEOUT_EN
  logic [24:0] idle_q, idle_d;
  logic [24:0] tmo_limit;
  logic        idle;

  assign tmo_limit = 25'(prescale) * 25'd320;
  assign idle      = !empty && !rx_busy && !push && !pop;

  always_comb begin
    idle_d = '0;
    if (idle) idle_d = (idle_q == '1) ? idle_q : idle_q + 1'b1;
    timeout_d = timeout_q;
    if (prescale == '0 || push || pop || empty) timeout_d = 1'b0;
    else if (idle_d >= tmo_limit)               timeout_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) idle_q <= '0;
    else        idle_q <= idle_d;
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{prescale, rx_busy};
  assign timeout_d  = 1'b0;
`endif

  // Interrupt is registered from next-state values so it lines up with the flags it reflects.
  always_comb begin
    lvl_d = (irq_thresh != '0) && (count_d >= irq_thresh);
    irq_d = lvl_d || timeout_d || ovr_d || ferr_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovr_q     <= 1'b0;
      ferr_q    <= 1'b0;
      timeout_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovr_q     <= ovr_d;
      ferr_q    <= ferr_d;
      timeout_q <= timeout_d;
      irq_q     <= irq_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= s_axis_tdata;
  end

  assign overrun_sticky   = ovr_q;
  assign frame_err_sticky = ferr_q;
`ifdef UART_RX_FIFO_TIMEOUT_EN
  assign timeout          = timeout_q;
`else
  assign timeout          = 1'b0;
`endif
  assign rx_irq           = irq_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: queued expected bytes are compared on every pop.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] s_axis_tdata;
  logic       s_axis_tvalid;
  logic       s_axis_tready;
  logic       rx_busy, rx_overrun, rx_frame_err;
  logic [15:0] prescale;
  logic       rd_en;
  logic [7:0] rd_data;
  logic [4:0] count;
  logic       empty, full;
  logic [4:0] irq_thresh;
  logic       clr_err;
  logic       overrun_sticky, frame_err_sticky, timeout, rx_irq;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [7:0]  sb_q [$];

  uart_rx_fifo #(.DATA_WIDTH(8), .DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .rx_busy(rx_busy), .rx_overrun(rx_overrun), .rx_frame_err(rx_frame_err),
    .prescale(prescale), .rd_en(rd_en), .rd_data(rd_data), .count(count),
    .empty(empty), .full(full), .irq_thresh(irq_thresh), .clr_err(clr_err),
    .overrun_sticky(overrun_sticky), .frame_err_sticky(frame_err_sticky),
    .timeout(timeout), .rx_irq(rx_irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    s_axis_tdata  = b;
    s_axis_tvalid = 1'b1;
    if (s_axis_tready) sb_q.push_back(b);
    tick();
    s_axis_tvalid = 1'b0;
  endtask

  task automatic pop_byte();
    logic [7:0] exp;
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : 8'hxx;
    check("rd_data", 32'(rd_data), 32'(exp));
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic check_count(input string tag);
    check(tag, 32'(count), sb_q.size());
    check({tag, "_empty"}, 32'(empty), 32'(sb_q.size() == 0));
    check({tag, "_full"}, 32'(full), 32'(sb_q.size() == 16));
  endtask

  initial begin
    rst_n = 1'b0; s_axis_tdata = '0; s_axis_tvalid = 1'b0; rx_busy = 1'b0;
    rx_overrun = 1'b0; rx_frame_err = 1'b0; prescale = '0; rd_en = 1'b0;
    irq_thresh = '0; clr_err = 1'b0;
    tick(); tick();
    check("rst_count", 32'(count), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_full", 32'(full), 0);
    check("rst_tready", 32'(s_axis_tready), 1);
    check("rst_irq", 32'(rx_irq), 0);
    check("rst_sticky", 32'({overrun_sticky, frame_err_sticky, timeout}), 0);
    rst_n = 1'b1;
    tick();

    // single byte through
    push_byte(8'h41);
    check_count("one_push");
    check("one_head", 32'(rd_data), 32'h41);
    pop_byte();
    check_count("one_pop");

    // push into empty with same-cycle rd_en: the pop is ignored
    s_axis_tdata = 8'h5A; s_axis_tvalid = 1'b1; rd_en = 1'b1;
    sb_q.push_back(8'h5A);
    tick();
    s_axis_tvalid = 1'b0; rd_en = 1'b0;
    check_count("push_rd_empty");
    pop_byte();

    // fill to full (pointers start at 2, so this wraps), refused 17th, drain
    for (int i = 0; i < 16; i++) push_byte(8'(i));
    check_count("fill");
    check("full_tready", 32'(s_axis_tready), 0);
    push_byte(8'hAA);
    check_count("overfill");
    for (int i = 0; i < 16; i++) pop_byte();
    check_count("drain");
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    check_count("rd_empty");

    // simultaneous push and pop at count 5
    for (int i = 0; i < 5; i++) push_byte(8'h10 + 8'(i));
    check("simul_head", 32'(rd_data), 32'(sb_q[0]));
    s_axis_tdata = 8'h55; s_axis_tvalid = 1'b1; rd_en = 1'b1;
    void'(sb_q.pop_front());
    sb_q.push_back(8'h55);
    tick();
    s_axis_tvalid = 1'b0; rd_en = 1'b0;
    check_count("simul");
    check("simul_adv", 32'(rd_data), 32'h11);
    for (int i = 0; i < 5; i++) pop_byte();
    check_count("simul_drain");

    // level interrupt
    irq_thresh = 5'd4;
    for (int i = 0; i < 3; i++) begin
      push_byte(8'hC0 + 8'(i));
      check("lvl_below", 32'(rx_irq), 0);
    end
    push_byte(8'hC3);
    check("lvl_at", 32'(rx_irq), 1);
    pop_byte();
    check("lvl_pop", 32'(rx_irq), 0);
    for (int i = 0; i < 3; i++) pop_byte();
    irq_thresh = '0;

    // sticky errors: set wins over clear
    rx_frame_err = 1'b1; clr_err = 1'b1; tick(); rx_frame_err = 1'b0; clr_err = 1'b0;
    check("ferr_set", 32'(frame_err_sticky), 1);
    check("ferr_irq", 32'(rx_irq), 1);
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    check("ferr_clr", 32'(frame_err_sticky), 0);
    check("ferr_irq_clr", 32'(rx_irq), 0);
    rx_overrun = 1'b1; tick(); rx_overrun = 1'b0;
    check("ovr_set", 32'({overrun_sticky, frame_err_sticky, rx_irq}), 32'b101);
    tick();
    check("ovr_hold", 32'(overrun_sticky), 1);
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    check("ovr_clr", 32'({overrun_sticky, rx_irq}), 0);

    // character timeout
    prescale = 16'd2;
    push_byte(8'h7E);
    for (int i = 0; i < 639; i++) tick();
    check("tmo_639", 32'(timeout), 0);
    tick();
`ifdef UART_RX_FIFO_TIMEOUT_EN
    check("tmo_640", 32'(timeout), 1);
    check("tmo_irq", 32'(rx_irq), 1);
`else
    check("tmo_640", 32'(timeout), 0);
    check("tmo_irq", 32'(rx_irq), 0);
`endif
    pop_byte();
    check("tmo_pop", 32'(timeout), 0);
    check("tmo_irq_pop", 32'(rx_irq), 0);
    prescale = '0;

    // asynchronous reset mid-operation
    for (int i = 0; i < 3; i++) push_byte(8'hE0 + 8'(i));
    #2 rst_n = 1'b0;
    #1;
    sb_q.delete();
    check_count("async_rst");
    tick();
    rst_n = 1'b1;
    tick();
    check_count("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter DATA_WIDTH, 8, character width; matches the upstream receiver.
REQ-002 Parameter DEPTH, 16, FIFO entries; power of two, >= 2; AW = log2(DEPTH).
REQ-003 clk  in  1  sole clock; all state on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 s_axis_tdata  in  DATA_WIDTH  received character from the receiver.
REQ-006 s_axis_tvalid  in  1  character valid.
REQ-007 s_axis_tready  out  1  FIFO can accept.
REQ-008 rx_busy  in  1  receiver busy flag (mid-frame).
REQ-009 rx_overrun  in  1  single-cycle overrun pulse from the receiver.
REQ-010 rx_frame_err  in  1  single-cycle frame-error pulse from the receiver.
REQ-011 prescale  in  16  same baud prescale value fed to the receiver.
REQ-012 rd_en  in  1  pop request from the register interface.
REQ-013 rd_data  out  DATA_WIDTH  head entry (show-ahead).
REQ-014 count  out  AW+1  occupancy, 0..DEPTH.
REQ-015 empty / full  out  1 each  count==0 / count==DEPTH.
REQ-016 irq_thresh  in  AW+1  level threshold; 0 disables the level interrupt.
REQ-017 clr_err  in  1  clear-sticky-errors pulse.
REQ-018 overrun_sticky / frame_err_sticky / timeout  out  1 each  status flags.
REQ-019 rx_irq  out  1  receive interrupt.

Function
REQ-020 s_axis_tready SHALL equal !full, combinationally from the registered count.
REQ-021 Push SHALL occur on s_axis_tvalid && s_axis_tready; data is written at wr_ptr; wr_ptr wraps modulo DEPTH.
REQ-022 Pop SHALL occur on rd_en && !empty; rd_ptr advances and wraps modulo DEPTH; rd_en while empty SHALL be ignored with no state change.
REQ-023 rd_data SHALL present mem[rd_ptr] combinationally; its value is undefined while empty.
REQ-024 Simultaneous push and pop SHALL leave count unchanged and move both pointers.
REQ-025 Push into an empty FIFO SHALL make rd_data valid and empty low on the next cycle (1-cycle latency); a same-cycle rd_en is ignored.
REQ-026 overrun_sticky SHALL set on rx_overrun, frame_err_sticky SHALL set on rx_frame_err; both SHALL clear on clr_err; a set SHALL win over a same-cycle clear.
REQ-027 Level interrupt: lvl = (irq_thresh != 0) && (count >= irq_thresh).
REQ-028 rx_irq SHALL be registered: lvl || timeout || overrun_sticky || frame_err_sticky.

Reset
REQ-029 On rst_n low: pointers, count = 0; empty = 1; full = 0; sticky flags, timeout, rx_irq = 0; idle counter = 0. Memory contents are not reset.
REQ-030 Reset asserted mid-operation SHALL discard all entries immediately, without waiting for a clock edge.

Configuration
REQ-031 Macro UART_RX_FIFO_TIMEOUT_EN SHALL enable character-timeout detection.
REQ-032 With the macro: a 25-bit idle counter SHALL increment each cycle while !empty && !rx_busy && no push && no pop, and SHALL reset to 0 otherwise.
REQ-033 With the macro: timeout SHALL assert when the idle counter reaches prescale*320 (4 characters of 10 bits at 8 clocks per prescale unit). It SHALL clear on the next push or pop, or when the FIFO goes empty. The counter SHALL saturate.
REQ-034 With the macro: prescale==0 SHALL hold timeout at 0.
REQ-035 Without the macro: no idle counter is built; timeout is tied to 0; all other behaviour is unchanged.

Verification
REQ-036 Push 0x41 into the empty FIFO -> next cycle empty=0, count=1, rd_data=0x41; rd_en -> count=0, empty=1.
REQ-037 DEPTH=16: push 16 bytes 0x00..0x0F -> full=1, s_axis_tready=0, a 17th tvalid is not accepted; pop all 16 -> data returned 0x00..0x0F in order, pointer wrap exercised.
REQ-038 count=5 with simultaneous push 0x55 and rd_en -> count stays 5, head advances, 0x55 is read last.
REQ-039 irq_thresh=4: push 3 bytes -> rx_irq=0; 4th push -> rx_irq=1 one cycle later; pop 1 -> rx_irq=0.
REQ-040 rx_frame_err pulse coinciding with clr_err -> frame_err_sticky=1 and rx_irq=1; clr_err alone next cycle -> both flags 0.
REQ-041 With the macro, prescale=2, 1 byte held, rx_busy=0 -> timeout=1 after 640 idle cycles, not at 639; rd_en -> timeout=0. Without the macro -> timeout never asserts.
